// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//
// Purpose:
//   Parametrised multi-read-port integer register file. It has a single write
//   port, NREAD independent registered read ports, an optional hardwired-zero
//   register 0 and optional forwarding of a same-edge write to a read. After
//   reset, or on a clear_req pulse, a sequencer zeroes the array one entry per
//   cycle. While it runs, busy is high, writes are dropped and reads return 0.
//
// Ports:
//   clk        in   1            clock, rising edge
//   resetn     in   1            asynchronous active-low reset
//   rd_en      in   NREAD        per-port read enable
//   rd_addr    in   NREAD*AW     read addresses, port p at [p*AW +: AW]
//   rd_data    out  NREAD*XLEN   registered read data, port p at [p*XLEN +: XLEN]
//   wen        in   1            write enable
//   waddr      in   AW           write address
//   wdata      in   XLEN         write data
//   clear_req  in   1            single-cycle request for a full array clear
//   busy       out  1            high while the clear sequencer runs
//
// NREGS must be a power of two (at least 2), so every address is in range.
// NREAD must be between 1 and 4.
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  wen,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic                  clear_req,
  output logic                  busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           idx_q, idx_d;
  logic [NREAD*XLEN-1:0]   rd_data_q, rd_data_d;

  // Storage has no reset; the clear sequencer is what zeroes it.
  logic [XLEN-1:0]         mem_q [NREGS];
  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [XLEN-1:0]         mem_wdata;

  // A writeback that actually lands in the array. Writes are dropped while
  // clearing and, with ZERO_REG, when targeting register 0. Only such
  // writes may be forwarded to a read.
  logic                    wr_ok;

  assign wr_ok = wen && (state_q == ST_READY) &&
                 !((ZERO_REG != 0) && (waddr == '0));

  // Clear sequencer: one entry per cycle; it leaves CLEAR after the last index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(NREGS - 1)) begin
          state_d = ST_READY;
          idx_d   = '0;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // Array write port is shared between the clear sequencer and writeback.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = waddr;
    mem_wdata = wdata;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = idx_q;
      mem_wdata = '0;
    end else if (wr_ok) begin
      mem_we = 1'b1;
    end
  end

  // Read ports. Disabled ports hold their value. Register 0 (with ZERO_REG)
  // beats forwarding, and forwarding beats the stored contents.
  always_comb begin
    rd_data_d = rd_data_q;
    for (int p = 0; p < NREAD; p++) begin
      if (rd_en[p]) begin
        if (state_q == ST_CLEAR) begin
          rd_data_d[p*XLEN +: XLEN] = '0;
        end else if ((ZERO_REG != 0) && (rd_addr[p*AW +: AW] == '0)) begin
          rd_data_d[p*XLEN +: XLEN] = '0;
        end else if ((BYPASS != 0) && wr_ok && (waddr == rd_addr[p*AW +: AW])) begin
          rd_data_d[p*XLEN +: XLEN] = wdata;
        end else begin
          rd_data_d[p*XLEN +: XLEN] = mem_q[rd_addr[p*AW +: AW]];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_CLEAR;
      idx_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//
// Purpose:
//   Self-checking bench for regfile_mp. Four instances run side by side:
//     dut_a  XLEN=32 NREGS=32 NREAD=2  ZERO_REG=1 BYPASS=1
//     dut_b  XLEN=32 NREGS=32 NREAD=2  ZERO_REG=1 BYPASS=0
//     dut_c  XLEN=32 NREGS=32 NREAD=2  ZERO_REG=0 BYPASS=1
//     dut_d  XLEN=64 NREGS=16 NREAD=4  ZERO_REG=1 BYPASS=1
//   dut_a/b/c share one stimulus group, and dut_d has its own. Each directed
//   vector pushes its hand-computed read results into a queue. A monitor pops
//   one entry for each read it sees and compares it with rd_data.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  logic clk = 1'b0;
  logic resetn;

  // Shared stimulus for the three 32x32 instances
  logic [1:0]  rd_en_s;
  logic [9:0]  rd_addr_s;
  logic        wen_s;
  logic [4:0]  waddr_s;
  logic [31:0] wdata_s;
  logic        clear_req_s;
  logic [63:0] rd_data_a, rd_data_b, rd_data_c;
  logic        busy_a, busy_b, busy_c;

  // Stimulus for the 64-bit, 16-entry, 4-port instance
  logic [3:0]   rd_en_d;
  logic [15:0]  rd_addr_d;
  logic         wen_d;
  logic [3:0]   waddr_d;
  logic [63:0]  wdata_d;
  logic         clear_req_d;
  logic [255:0] rd_data_d;
  logic         busy_d;

  typedef struct {
    int          dut;
    int          port;
    logic [63:0] expv;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  logic [1:0] mon_en_s;
  logic [3:0] mon_en_d;
  int   cnt_a, cnt_b, cnt_c, cnt_d;

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .resetn(resetn), .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_a),
    .wen(wen_s), .waddr(waddr_s), .wdata(wdata_s), .clear_req(clear_req_s), .busy(busy_a));

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .resetn(resetn), .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_b),
    .wen(wen_s), .waddr(waddr_s), .wdata(wdata_s), .clear_req(clear_req_s), .busy(busy_b));

  regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(0), .BYPASS(1)) dut_c (
    .clk(clk), .resetn(resetn), .rd_en(rd_en_s), .rd_addr(rd_addr_s), .rd_data(rd_data_c),
    .wen(wen_s), .waddr(waddr_s), .wdata(wdata_s), .clear_req(clear_req_s), .busy(busy_c));

  regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(4), .ZERO_REG(1), .BYPASS(1)) dut_d (
    .clk(clk), .resetn(resetn), .rd_en(rd_en_d), .rd_addr(rd_addr_d), .rd_data(rd_data_d),
    .wen(wen_d), .waddr(waddr_d), .wdata(wdata_d), .clear_req(clear_req_d), .busy(busy_d));

  // 10-unit clock period
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%h, want 0x%h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] portData(input int dut, input int port);
    case (dut)
      0:       return {32'h0, rd_data_a[port*32 +: 32]};
      1:       return {32'h0, rd_data_b[port*32 +: 32]};
      2:       return {32'h0, rd_data_c[port*32 +: 32]};
      default: return rd_data_d[port*64 +: 64];
    endcase
  endfunction

  task automatic popCheck(input int d, input int p);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL read dut%0d port%0d: got 0x%h, want no read (queue empty)",
               d, p, portData(d, p));
    end else begin
      e = sb.pop_front();
      if (e.dut != d || e.port != p) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL read order: got dut%0d port%0d, want dut%0d port%0d",
                 d, p, e.dut, e.port);
      end else begin
        checkOutput($sformatf("rd_data dut%0d port%0d", d, p), portData(d, p), e.expv);
      end
    end
  endtask

  // Monitor: an enabled port shows its new rd_data after the edge, so capture
  // the enables at the edge and compare shortly after.
  always begin
    @(posedge clk);
    mon_en_s = rd_en_s;
    mon_en_d = rd_en_d;
    #1;
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < 2; p++)
        if (mon_en_s[p]) popCheck(d, p);
    for (int p = 0; p < 4; p++)
      if (mon_en_d[p]) popCheck(3, p);
  end

  // Drive one cycle of shared stimulus. The ea*/eb*/ec* arguments are the
  // read results expected from dut_a/b/c.
  task automatic applyStimulus(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                               input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [31:0] ea0, input logic [31:0] ea1,
                               input logic [31:0] eb0, input logic [31:0] eb1,
                               input logic [31:0] ec0, input logic [31:0] ec1);
    logic [31:0] ex [3][2];
    ex[0][0] = ea0; ex[0][1] = ea1;
    ex[1][0] = eb0; ex[1][1] = eb1;
    ex[2][0] = ec0; ex[2][1] = ec1;
    rd_en_s   = en;
    rd_addr_s = {a1, a0};
    wen_s     = we;
    waddr_s   = wa;
    wdata_s   = wd;
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < 2; p++)
        if (en[p]) sb.push_back('{dut: d, port: p, expv: {32'h0, ex[d][p]}});
    @(negedge clk);
  endtask

  task automatic applySame(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                           input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [31:0] e0, input logic [31:0] e1);
    applyStimulus(en, a0, a1, we, wa, wd, e0, e1, e0, e1, e0, e1);
  endtask

  task automatic idleS();
    applySame(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic applyStimulusD(input logic [3:0] en, input logic [3:0] a0, input logic [3:0] a1,
                                input logic [3:0] a2, input logic [3:0] a3,
                                input logic we, input logic [3:0] wa, input logic [63:0] wd,
                                input logic [63:0] e0, input logic [63:0] e1,
                                input logic [63:0] e2, input logic [63:0] e3);
    logic [63:0] ex [4];
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    rd_en_d   = en;
    rd_addr_d = {a3, a2, a1, a0};
    wen_d     = we;
    waddr_d   = wa;
    wdata_d   = wd;
    for (int p = 0; p < 4; p++)
      if (en[p]) sb.push_back('{dut: 3, port: p, expv: ex[p]});
    @(negedge clk);
  endtask

  task automatic idleD();
    applyStimulusD(4'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
  endtask

  // Count busy cycles on every instance over a fixed window (idle stimulus)
  task automatic countBusy(input int window);
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
    for (int i = 0; i < window; i++) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      if (busy_c) cnt_c++;
      if (busy_d) cnt_d++;
      idleS();
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    resetn = 1'b1;
    rd_en_s = '0; rd_addr_s = '0; wen_s = 1'b0; waddr_s = '0; wdata_s = '0; clear_req_s = 1'b0;
    rd_en_d = '0; rd_addr_d = '0; wen_d = 1'b0; waddr_d = '0; wdata_d = '0; clear_req_d = 1'b0;
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset busy_a", {63'h0, busy_a}, 64'h1);
    checkOutput("reset busy_d", {63'h0, busy_d}, 64'h1);
    checkOutput("reset rd_data_a", rd_data_a, 64'h0);
    for (int p = 0; p < 4; p++)
      checkOutput($sformatf("reset rd_data_d port%0d", p), rd_data_d[p*64 +: 64], 64'h0);

    $display("[TB] clear after reset release");
    resetn = 1'b1;
    countBusy(40);
    checkOutput("busy cycles a after reset", 64'(cnt_a), 64'd32);
    checkOutput("busy cycles b after reset", 64'(cnt_b), 64'd32);
    checkOutput("busy cycles c after reset", 64'(cnt_c), 64'd32);
    checkOutput("busy cycles d after reset", 64'(cnt_d), 64'd16);

    for (int r = 0; r < 32; r++)
      applySame(2'b11, 5'(r), 5'(31 - r), 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    idleS();

    $display("[TB] basic write/read, bypass, zero register");
    applySame(2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0);
    applySame(2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
    applyStimulus(2'b11, 5'd7, 5'd5, 1'b1, 5'd7, 32'h12345678,
                  32'h12345678, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF);
    applySame(2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 32'h12345678, 32'h12345678);
    applyStimulus(2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(2'b11, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF);

    $display("[TB] disabled ports hold");
    applySame(2'b11, 5'd7, 5'd5, 1'b0, 5'd0, 32'h0, 32'h12345678, 32'hDEADBEEF);
    applySame(2'b01, 5'd5, 5'd7, 1'b1, 5'd7, 32'hCAFEF00D, 32'hDEADBEEF, 32'h0);
    checkOutput("hold port1 a", {32'h0, rd_data_a[63:32]}, 64'hDEADBEEF);
    applySame(2'b00, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    checkOutput("hold port0 b", {32'h0, rd_data_b[31:0]}, 64'hDEADBEEF);
    checkOutput("hold port1 c", {32'h0, rd_data_c[63:32]}, 64'hDEADBEEF);
    applySame(2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D);

    $display("[TB] fill then clear");
    for (int r = 1; r < 32; r++)
      applySame(2'b00, 5'd0, 5'd0, 1'b1, 5'(r), 32'h10000000 + 32'(r), 32'h0, 32'h0);
    applySame(2'b11, 5'd9, 5'd31, 1'b0, 5'd0, 32'h0, 32'h10000009, 32'h1000001F);
    applyStimulus(2'b11, 5'd0, 5'd3, 1'b0, 5'd0, 32'h0,
                  32'h0, 32'h10000003, 32'h0, 32'h10000003, 32'hFFFFFFFF, 32'h10000003);
    clear_req_s = 1'b1;
    idleS();
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      if (busy_c) cnt_c++;
      clear_req_s = (i == 10);
      if (i == 5)
        applySame(2'b11, 5'd3, 5'd5, 1'b1, 5'd3, 32'h000000AA, 32'h0, 32'h0);
      else
        idleS();
    end
    clear_req_s = 1'b0;
    checkOutput("busy cycles a clear_req", 64'(cnt_a), 64'd32);
    checkOutput("busy cycles b clear_req", 64'(cnt_b), 64'd32);
    checkOutput("busy cycles c clear_req", 64'(cnt_c), 64'd32);
    for (int r = 0; r < 32; r++)
      applySame(2'b11, 5'(r), 5'(31 - r), 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);

    $display("[TB] reset in the middle of a clear");
    applySame(2'b00, 5'd0, 5'd0, 1'b1, 5'd12, 32'h5A5A5A5A, 32'h0, 32'h0);
    applySame(2'b11, 5'd12, 5'd12, 1'b0, 5'd0, 32'h0, 32'h5A5A5A5A, 32'h5A5A5A5A);
    resetn = 1'b0;
    #1;
    checkOutput("async reset rd_data_a", rd_data_a, 64'h0);
    checkOutput("async reset busy_a", {63'h0, busy_a}, 64'h1);
    idleS();
    resetn = 1'b1;
    repeat (10) idleS();
    resetn = 1'b0;
    idleS();
    resetn = 1'b1;
    countBusy(40);
    checkOutput("busy cycles a mid-clear reset", 64'(cnt_a), 64'd32);
    checkOutput("busy cycles d mid-clear reset", 64'(cnt_d), 64'd16);
    applySame(2'b11, 5'd12, 5'd12, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    idleS();

    $display("[TB] 64-bit 16-entry 4-port instance");
    applyStimulusD(4'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd1, 64'h0123456789ABCDEF, 64'h0, 64'h0, 64'h0, 64'h0);
    applyStimulusD(4'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd2, 64'hFEDCBA9876543210, 64'h0, 64'h0, 64'h0, 64'h0);
    applyStimulusD(4'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd3, 64'h00000000FFFFFFFF, 64'h0, 64'h0, 64'h0, 64'h0);
    applyStimulusD(4'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'd4, 64'hFFFFFFFF00000000, 64'h0, 64'h0, 64'h0, 64'h0);
    applyStimulusD(4'hF, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 4'd0, 64'h0,
                   64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h00000000FFFFFFFF, 64'hFFFFFFFF00000000);
    applyStimulusD(4'hF, 4'd4, 4'd3, 4'd2, 4'd1, 1'b0, 4'd0, 64'h0,
                   64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF);
    applyStimulusD(4'hF, 4'd2, 4'd2, 4'd2, 4'd2, 1'b0, 4'd0, 64'h0,
                   64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210);
    applyStimulusD(4'hF, 4'd6, 4'd1, 4'd0, 4'd6, 1'b1, 4'd6, 64'hA5A5A5A55A5A5A5A,
                   64'hA5A5A5A55A5A5A5A, 64'h0123456789ABCDEF, 64'h0, 64'hA5A5A5A55A5A5A5A);
    applyStimulusD(4'h2, 4'd0, 4'd2, 4'd0, 4'd0, 1'b0, 4'd0, 64'h0,
                   64'h0, 64'hFEDCBA9876543210, 64'h0, 64'h0);
    checkOutput("hold d port0", rd_data_d[63:0], 64'hA5A5A5A55A5A5A5A);
    checkOutput("hold d port3", rd_data_d[255:192], 64'hA5A5A5A55A5A5A5A);
    applyStimulusD(4'hF, 4'd0, 4'd0, 4'd4, 4'd0, 1'b1, 4'd0, 64'hFFFFFFFFFFFFFFFF,
                   64'h0, 64'h0, 64'hFFFFFFFF00000000, 64'h0);

    clear_req_d = 1'b1;
    idleD();
    clear_req_d = 1'b0;
    cnt_d = 0;
    for (int i = 0; i < 24; i++) begin
      if (busy_d) cnt_d++;
      idleD();
    end
    checkOutput("busy cycles d clear_req", 64'(cnt_d), 64'd16);
    applyStimulusD(4'hF, 4'd1, 4'd2, 4'd3, 4'd6, 1'b0, 4'd0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0);
    repeat (3) idleD();

    checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
